// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_pkg
//  Purpose  : Shared definitions for the ALU issue/capture controller.
//             Contents: ALU opcode encodings, FSM state encoding (2-bit),
//             response flag bit positions, and a helper that identifies
//             the signed arithmetic opcodes.
//  Revision : 1.0  initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    // ALU opcodes
    localparam logic [2:0] OP_UADD = 3'b000;
    localparam logic [2:0] OP_SADD = 3'b001;
    localparam logic [2:0] OP_USUB = 3'b010;
    localparam logic [2:0] OP_SSUB = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_DIV2 = 3'b111;

    // Bit positions inside rsp_flags = {carryout, overflow, zero}
    localparam int FLG_C = 2;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Overflow is only meaningful for the two's-complement opcodes.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_SADD) || (op == OP_SSUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_fifo
//  Purpose  : Synchronous request FIFO with registered full/empty flags.
//             Pointers carry one extra wrap bit so full and empty are
//             distinguished without a separate counter.
//  Ports    : clk, rst     clock, synchronous active-high reset
//             i_push       write i_data (ignored while full)
//             i_data       entry to store
//             i_pop        discard head (ignored while empty)
//             o_data       current head entry (first-word fall-through)
//             o_full       registered: DEPTH entries stored
//             o_empty      registered: no entries stored
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;
    logic [PW-1:0]    w_used_nxt;

    assign w_do_push  = i_push && !r_full;
    assign w_do_pop   = i_pop  && !r_empty;
    assign w_wr_nxt   = w_do_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    assign w_rd_nxt   = w_do_pop  ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
    // Modular difference of the extended pointers is the occupancy.
    assign w_used_nxt = w_wr_nxt - w_rd_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_full   <= (w_used_nxt == PW'(DEPTH));
            r_empty  <= (w_used_nxt == '0);
        end
    end

    // Storage needs no reset: only entries written since reset are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Issue/capture controller in front of a registered ALU with a
//             one-cycle result latency. Requests are queued, issued one at a
//             time on the alu_* operand registers, the result and flags are
//             captured two edges later and offered on a valid/ready response
//             port. Maintains a sticky signed-overflow bit and a 16-bit
//             completed-operation counter.
//  Ports    : clk, reset                   clock, synchronous active-high reset
//             req_valid/ready/a/b/opcode   request handshake and payload
//             alu_a/alu_b/alu_opcode       registered operands to the ALU
//             alu_result/carryout/overflow/zero   ALU outputs
//             rsp_valid/ready/result/flags/opcode response handshake/payload
//             clr_sticky, sticky_ovf       sticky overflow clear / status
//             op_count                     accepted-response counter
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int NUMBITS = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUMBITS-1:0] req_a,
    input  logic [NUMBITS-1:0] req_b,
    input  logic [2:0]         req_opcode,
    output logic [NUMBITS-1:0] alu_a,
    output logic [NUMBITS-1:0] alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUMBITS-1:0] rsp_result,
    output logic [2:0]         rsp_flags,
    output logic [2:0]         rsp_opcode,
    input  logic               clr_sticky,
    output logic               sticky_ovf,
    output logic [15:0]        op_count
);

    localparam int FIFO_W = 2 * NUMBITS + 3;

    state_t             r_state;
    logic [NUMBITS-1:0] r_alu_a;
    logic [NUMBITS-1:0] r_alu_b;
    logic [2:0]         r_alu_opcode;
    logic               r_rsp_valid;
    logic [NUMBITS-1:0] r_rsp_result;
    logic [2:0]         r_rsp_flags;
    logic [2:0]         r_rsp_opcode;
    logic               r_sticky_ovf;
    logic [15:0]        r_op_count;

    logic [FIFO_W-1:0]  w_push_data;
    logic [FIFO_W-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_rsp_fire;
    logic               w_sticky_set;
    logic [2:0]         w_flags;

    // FIFO entry layout: {A, B, opcode}
    assign w_push_data = {req_a, req_b, req_opcode};
    assign w_push      = req_valid && !w_full;
    assign w_rsp_fire  = r_rsp_valid && rsp_ready;

    // The head is taken either from IDLE or back-to-back with a response
    // handshake, so the next op issues on the same edge the response leaves.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_RESP) && w_rsp_fire));

    assign w_sticky_set = (r_state == ST_WAIT) && alu_overflow &&
                          is_signed_op(r_alu_opcode);

    always_comb begin
        w_flags        = '0;
        w_flags[FLG_C] = alu_carryout;
        w_flags[FLG_V] = alu_overflow;
        w_flags[FLG_Z] = alu_zero;
    end

    alu_issue_ctrl_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_opcode <= '0;
            r_sticky_ovf <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_alu_a      <= w_head[FIFO_W-1 -: NUMBITS];
                        r_alu_b      <= w_head[3 +: NUMBITS];
                        r_alu_opcode <= w_head[2:0];
                        r_state      <= ST_ISSUE;
                    end
                end
                // Operands are stable; the ALU registers its result here.
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= w_flags;
                    r_rsp_opcode <= r_alu_opcode;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_op_count  <= r_op_count + 16'd1;
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_a      <= w_head[FIFO_W-1 -: NUMBITS];
                            r_alu_b      <= w_head[3 +: NUMBITS];
                            r_alu_opcode <= w_head[2:0];
                            r_state      <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A capture-time overflow takes priority over a same-cycle clear.
            if (w_sticky_set) begin
                r_sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky_ovf <= 1'b0;
            end
        end
    end

    assign req_ready  = !w_full;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_opcode = r_rsp_opcode;
    assign sticky_ovf = r_sticky_ovf;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Self-checking bench for alu_issue_ctrl with a behavioural
//             registered ALU and a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [N-1:0]  req_a = '0;
    logic [N-1:0]  req_b = '0;
    logic [2:0]    req_opcode = '0;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [2:0]    alu_opcode;
    logic [N-1:0]  alu_result = '0;
    logic          alu_carryout = 1'b0;
    logic          alu_overflow = 1'b0;
    logic          alu_zero = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  rsp_result;
    logic [2:0]    rsp_flags;
    logic [2:0]    rsp_opcode;
    logic          clr_sticky = 1'b0;
    logic          sticky_ovf;
    logic [15:0]   op_count;

    logic          inj_ovf = 1'b0;
    bit            rnd_mode = 1'b0;

    int            n_tests = 0;
    int            n_fail = 0;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic         inj;
    } req_t;

    req_t          q[$];
    logic [N-1:0]  log_res[$];
    logic [2:0]    log_flg[$];
    logic [15:0]   exp_count = '0;
    int            n_rsp = 0;
    int            sticky_hits = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NUMBITS(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_opcode   (req_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_opcode   (rsp_opcode),
        .clr_sticky   (clr_sticky),
        .sticky_ovf   (sticky_ovf),
        .op_count     (op_count)
    );

    // ALU behaviour: returns {result, carry, overflow, zero}.
    function automatic logic [N+2:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [2:0] op);
        logic [N:0]   s;
        logic [N-1:0] r;
        logic         c;
        logic         v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            OP_UADD, OP_SADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[N-1:0];
                c = s[N];
                if (op == OP_SADD) v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            OP_USUB, OP_SSUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[N-1:0];
                c = s[N];
                if (op == OP_SSUB) v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a >> 1;
        endcase
        return {r, c, v, (r == '0)};
    endfunction

    // Registered ALU model, one cycle of latency; inj_ovf forces the overflow flag.
    always @(posedge clk) begin
        logic [N+2:0] f;
        f = alu_fn(alu_a, alu_b, alu_opcode);
        alu_result   <= f[N+2:3];
        alu_carryout <= f[2];
        alu_overflow <= f[1] | inj_ovf;
        alu_zero     <= f[0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference model: every response must match the oldest outstanding request.
    task automatic monitor();
        logic [N+2:0] e;
        logic [2:0]   ef;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                exp_count = '0;
            end else begin
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        check("rsp_spurious", 32'(rsp_valid), 32'd0);
                    end else begin
                        e  = alu_fn(q[0].a, q[0].b, q[0].op);
                        ef = {e[2], e[1] | q[0].inj, e[0]};
                        check("rsp_result", 32'(rsp_result), 32'(e[N+2:3]));
                        check("rsp_flags",  32'(rsp_flags),  32'(ef));
                        check("rsp_opcode", 32'(rsp_opcode), 32'(q[0].op));
                        if (rsp_ready) begin
                            log_res.push_back(rsp_result);
                            log_flg.push_back(rsp_flags);
                            if (ef[1] && (q[0].op == OP_SADD || q[0].op == OP_SSUB))
                                sticky_hits++;
                            exp_count = exp_count + 16'd1;
                            n_rsp++;
                            void'(q.pop_front());
                        end
                    end
                end
                if (req_valid && req_ready)
                    q.push_back('{a: req_a, b: req_b, op: req_opcode, inj: inj_ovf});
            end
        end
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        bit acc;
        int t;
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_opcode = op;
        t = 0;
        do begin
            acc = req_ready;
            tick();
            t++;
        end while (!acc && t < 200);
        if (!acc) check("push_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int target);
        int t;
        t = 0;
        while (n_rsp < target && t < 300) begin
            tick();
            t++;
        end
        check(tag, 32'(n_rsp >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((q.size() != 0 || rsp_valid) && t < 400) begin
            tick();
            t++;
        end
        check(tag, 32'(q.size() == 0 && !rsp_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int tgt;
        int t;
        int snap;
        bit seen;
        logic [N-1:0] ta[5];
        logic [N-1:0] tb_[5];

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_opcode), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        reset = 1'b0;

        // 1: latency of 3 edges from acceptance
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_a      = 16'hFFFF;
        req_b      = 16'h0001;
        req_opcode = OP_UADD;
        tick();
        req_valid = 1'b0;
        check("t1_lat0", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_lat1", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_lat2", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_lat3", 32'(rsp_valid), 32'd1);
        check("t1_result", 32'(rsp_result), 32'h0000);
        check("t1_flags", 32'(rsp_flags), 32'b101);
        tick();

        // 2: ordering of two responses
        base = log_res.size();
        tgt  = n_rsp + 2;
        push(16'h0001, 16'h0002, OP_USUB);
        push(16'h0001, 16'h0000, OP_DIV2);
        wait_rsp("t2_timeout", tgt);
        check("t2_res0", 32'(log_res[base]), 32'hFFFF);
        check("t2_flg0", 32'(log_flg[base]), 32'b100);
        check("t2_res1", 32'(log_res[base+1]), 32'h0000);
        check("t2_flg1", 32'(log_flg[base+1]), 32'b001);

        // 3: backpressure fills response regs plus FIFO
        wait_idle("t3_idle");
        rsp_ready = 1'b0;
        base = log_res.size();
        for (int i = 0; i < 5; i++) begin
            ta[i]  = 16'hFF00 | 16'(i * 17);
            tb_[i] = 16'h0FFF ^ 16'(i * 3);
            push(ta[i], tb_[i], OP_AND);
        end
        req_valid  = 1'b1;
        req_a      = 16'hAAAA;
        req_b      = 16'h5555;
        req_opcode = OP_AND;
        check("t3_ready6", 32'(req_ready), 32'd0);
        repeat (3) tick();
        check("t3_ready6_hold", 32'(req_ready), 32'd0);
        check("t3_rsp_held", 32'(rsp_valid), 32'd1);
        req_valid = 1'b0;
        tgt = n_rsp + 5;
        rsp_ready = 1'b1;
        wait_rsp("t3_timeout", tgt);
        for (int i = 0; i < 5; i++)
            check("t3_order", 32'(log_res[base+i]), 32'(ta[i] & tb_[i]));
        check("t3_count", 32'(op_count), 32'(exp_count));

        // 4: sticky overflow
        wait_idle("t4_idle");
        inj_ovf = 1'b1;
        base = log_res.size();
        tgt  = n_rsp + 1;
        push(16'h0001, 16'h0001, OP_UADD);
        wait_rsp("t4_timeout_a", tgt);
        inj_ovf = 1'b0;
        check("t4_inj_flag", 32'(log_flg[base][1]), 32'd1);
        check("t4_unsigned_no_sticky", 32'(sticky_ovf), 32'd0);
        clr_sticky = 1'b1;
        push(16'h8000, 16'h0001, OP_SSUB);
        t = 0;
        while (!rsp_valid && t < 20) begin
            tick();
            t++;
        end
        clr_sticky = 1'b0;
        check("t4_rsp_seen", 32'(rsp_valid), 32'd1);
        check("t4_set_wins", 32'(sticky_ovf), 32'd1);
        repeat (2) tick();
        check("t4_sticky_hold", 32'(sticky_ovf), 32'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("t4_cleared", 32'(sticky_ovf), 32'd0);

        // 5: reset while in WAIT with two ops queued
        wait_idle("t5_idle");
        req_valid  = 1'b1;
        req_a      = 16'h0011;
        req_b      = 16'h0022;
        req_opcode = OP_OR;
        tick();
        req_a = 16'h0033;
        tick();
        req_a = 16'h0044;
        tick();
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_req_ready", 32'(req_ready), 32'd1);
        check("t5_op_count", 32'(op_count), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | rsp_valid;
        end
        check("t5_no_stale_rsp", 32'(seen), 32'd0);
        base = log_res.size();
        tgt  = n_rsp + 1;
        push(16'h1234, 16'h0F0F, OP_XOR);
        wait_rsp("t5_timeout", tgt);
        check("t5_fresh_res", 32'(log_res[base]), 32'h1D3B);
        check("t5_fresh_count", 32'(op_count), 32'd1);

        // Randomized traffic with random response backpressure
        wait_idle("rnd_idle0");
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("rnd_sticky_clr", 32'(sticky_ovf), 32'd0);
        snap = sticky_hits;
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            push(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
        end
        rnd_mode  = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("rnd_drain");
        check("rnd_sticky", 32'(sticky_ovf), 32'(sticky_hits > snap));
        check("rnd_count", 32'(op_count), 32'(exp_count));

        // 6: counter wrap
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        check("t6_preload", 32'(op_count), 32'hFFFF);
        tgt = n_rsp + 1;
        push(16'h00FF, 16'h0F0F, OP_XOR);
        wait_rsp("t6_timeout", tgt);
        tick();
        check("t6_wrap", 32'(op_count), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
